// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: buffers signed audio samples and feeds them, held per sample period, to the delta-sigma DAC.
// Ports: clk/reset_n (async active-low reset); tick_inc phase step per clk;
// s_data/s_valid/s_ready sample input handshake; underrun_clr clears sticky underrun;
// dac_in offset-binary held sample; nco DAC update enable; sample_strobe sample boundary;
// fifo_count buffered entries; underrun sticky boundary-with-empty-FIFO flag.
module dac_sample_feeder #(
  parameter int N          = 8,
  parameter int ACC_W      = 16,
  parameter int OSR_LOG2   = 2,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ACC_W-1:0]      tick_inc,
  input  logic [N-1:0]          s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  underrun_clr,
  output logic [N-1:0]          dac_in,
  output logic                  nco,
  output logic                  sample_strobe,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  underrun
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W:0]        sum;
  logic [OSR_LOG2-1:0]   tcnt;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [N-1:0]          mem [DEPTH];
  logic [N-1:0]          head;
  logic                  boundary, push, pop, empty;
  assign s_ready = fifo_count != (DEPTH_LOG2+1)'(DEPTH);
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, tick_inc};
    boundary = sum[ACC_W] && &tcnt;
    empty    = fifo_count == '0;
    push     = s_valid && s_ready;
    pop      = boundary && !empty;
    head     = mem[rd_ptr];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      acc           <= '0;
      nco           <= 1'b0;
      sample_strobe <= 1'b0;
      tcnt          <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      dac_in        <= {1'b1, {(N-1){1'b0}}};
      underrun      <= 1'b0;
    end else begin
      acc           <= sum[ACC_W-1:0];
      nco           <= sum[ACC_W];
      sample_strobe <= boundary;
      tcnt          <= tcnt + OSR_LOG2'(sum[ACC_W]);
      fifo_count    <= fifo_count + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        dac_in <= {~head[N-1], head[N-2:0]};
      end
      // a new underrun event outranks a simultaneous clear
      if (boundary && empty) underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= s_data;
endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb_dac_sample_feeder: directed scenarios for dac_sample_feeder with hand-computed expectations.
module tb_dac_sample_feeder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] tick_inc = '0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        underrun_clr = 1'b0;
  logic [7:0]  dac_in;
  logic        nco;
  logic        sample_strobe;
  logic [2:0]  fifo_count;
  logic        underrun;
  int checks = 0;
  int failures = 0;

  dac_sample_feeder #(.N(8), .ACC_W(16), .OSR_LOG2(2), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset_n(reset_n), .tick_inc(tick_inc), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .underrun_clr(underrun_clr),
    .dac_in(dac_in), .nco(nco), .sample_strobe(sample_strobe),
    .fifo_count(fifo_count), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic wait_strobe(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_strobe && n < 64);
    checks++;
    if (sample_strobe !== 1'b1) begin
      failures++;
      $display("FAIL %s strobe_timeout got=%b want=1 within 64 clks", tag, sample_strobe);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({dac_in, nco, sample_strobe, s_ready, fifo_count, underrun} !== {8'h80, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got dac=%h nco=%b strb=%b rdy=%b cnt=%0d und=%b want 80 0 0 1 0 0",
               dac_in, nco, sample_strobe, s_ready, fifo_count, underrun);
    end
  endtask

  task automatic test_nco();
    int ncnt = 0, scnt = 0, last_n = -1, last_s = -1, bad_gap = 0, bad_coin = 0, zcnt = 0;
    tick_inc = 16'h4000;
    reset_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (nco) begin
        if (last_n >= 0 && i - last_n != 4) bad_gap++;
        last_n = i;
        ncnt++;
      end
      if (sample_strobe) begin
        if (!nco) bad_coin++;
        if (last_s >= 0 && i - last_s != 16) bad_gap++;
        last_s = i;
        scnt++;
      end
    end
    checks++;
    if (ncnt != 16) begin failures++; $display("FAIL nco_count got=%0d want=16", ncnt); end
    checks++;
    if (scnt != 4) begin failures++; $display("FAIL strobe_count got=%0d want=4", scnt); end
    checks++;
    if (bad_gap != 0) begin failures++; $display("FAIL pulse_spacing bad=%0d want=0", bad_gap); end
    checks++;
    if (bad_coin != 0) begin failures++; $display("FAIL strobe_nco_coincide bad=%0d want=0", bad_coin); end
    tick_inc = 16'h0000;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (nco || sample_strobe) zcnt++;
    end
    checks++;
    if (zcnt != 0) begin failures++; $display("FAIL zero_inc_pulses got=%0d want=0", zcnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4];
    logic [7:0] exp  [4];
    vals = '{8'h80, 8'h00, 8'h7F, 8'hFF};
    exp  = '{8'h00, 8'h80, 8'hFF, 8'h7F};
    checks++;
    if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_after_idle got=%b want=1", underrun); end
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_clear_idle got=%b want=0", underrun); end
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data = vals[i];
      @(negedge clk);
    end
    checks++;
    if (s_ready !== 1'b0 || fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL fill_full got rdy=%b cnt=%0d want rdy=0 cnt=4", s_ready, fifo_count);
    end
    s_data = 8'h55;
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd4) begin failures++; $display("FAIL fifth_push_rejected got cnt=%0d want=4", fifo_count); end
    tick_inc = 16'h4000;
    for (int i = 0; i < 4; i++) begin
      wait_strobe("drain");
      checks++;
      if (dac_in !== exp[i] || fifo_count !== 3'(3 - i)) begin
        failures++;
        $display("FAIL drain_%0d got dac=%h cnt=%0d want dac=%h cnt=%0d", i, dac_in, fifo_count, exp[i], 3 - i);
      end
    end
    checks++;
    if (underrun !== 1'b0) begin failures++; $display("FAIL no_underrun_while_full got=%b want=0", underrun); end
  endtask

  task automatic test_underrun();
    wait_strobe("underrun");
    checks++;
    if (dac_in !== 8'h7F || underrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun_hold got dac=%h und=%b want dac=7f und=1", dac_in, underrun);
    end
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_clr got=%b want=0", underrun); end
    underrun_clr = 1'b1;
    wait_strobe("set_vs_clr");
    checks++;
    if (underrun !== 1'b1) begin failures++; $display("FAIL set_wins_over_clr got=%b want=1", underrun); end
    @(negedge clk);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin failures++; $display("FAIL clr_after_set got=%b want=0", underrun); end
  endtask

  task automatic test_push_on_boundary();
    wait_strobe("pob_sync");
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (underrun !== 1'b0 || sample_strobe !== 1'b0) begin
      failures++;
      $display("FAIL pob_pre got und=%b strb=%b want 0 0", underrun, sample_strobe);
    end
    s_valid = 1'b1;
    s_data = 8'h10;
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (sample_strobe !== 1'b1 || underrun !== 1'b1 || dac_in !== 8'h7F || fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL pob_edge got strb=%b und=%b dac=%h cnt=%0d want 1 1 7f 1",
               sample_strobe, underrun, dac_in, fifo_count);
    end
    wait_strobe("pob_next");
    checks++;
    if (dac_in !== 8'h90 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL pob_next got dac=%h cnt=%0d want dac=90 cnt=0", dac_in, fifo_count);
    end
  endtask

  task automatic test_stream();
    int sent = 0, rcv = 0, cyc = 0;
    tick_inc = 16'h0000;
    @(negedge clk);
    while (sent < 4) begin
      s_valid = 1'b1;
      s_data = 8'(sent * 37 + 5);
      sent++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    tick_inc = 16'h8000;
    while (rcv < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (sample_strobe) begin
        checks++;
        if (dac_in !== (8'(rcv * 37 + 5) ^ 8'h80)) begin
          failures++;
          $display("FAIL stream_%0d got=%h want=%h", rcv, dac_in, 8'(rcv * 37 + 5) ^ 8'h80);
        end
        rcv++;
      end
      if (s_ready && sent < 1000) begin
        s_valid = 1'b1;
        s_data = 8'(sent * 37 + 5);
        sent++;
      end else s_valid = 1'b0;
    end
    s_valid = 1'b0;
    checks++;
    if (rcv != 1000) begin failures++; $display("FAIL stream_count got=%0d want=1000", rcv); end
    checks++;
    if (underrun !== 1'b0) begin failures++; $display("FAIL stream_underrun got=%b want=0", underrun); end
  endtask

  task automatic test_reset_midstream();
    tick_inc = 16'h0000;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data = 8'(i + 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd3) begin failures++; $display("FAIL midstream_fill got=%0d want=3", fifo_count); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (fifo_count !== 3'd0 || dac_in !== 8'h80 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got cnt=%0d dac=%h rdy=%b want 0 80 1", fifo_count, dac_in, s_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_nco();
    test_back_to_back();
    test_underrun();
    test_push_on_boundary();
    test_stream();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
